sm_addsub_pipe: RTL and testbench
=================================

Name: sm_addsub_pipe

Overview:
- Pipelined, parametrised sign-magnitude adder/subtractor.
- Operand MSB is the sign (1 = negative); the remaining N-1 bits are the magnitude.
- Successor to the combinational sign-magnitude subtractor. Adds an add/sub mode, a valid/ready handshake, a two-stage pipeline, negative-zero normalisation, optional saturation and zero/overflow flags.
- Sits between the operand register file and the result writeback in the arithmetic datapath.

Parameters:
- N, 8: total operand/result width including sign bit; N >= 2.
- SATURATE, 0: 0 = magnitude wraps modulo 2^(N-1) on overflow; 1 = magnitude clamps to all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand pair and op are valid this cycle.
- in_ready  output  1  block accepts the operand pair this cycle.
- in_a  input  N  operand A, sign-magnitude.
- in_b  input  N  operand B, sign-magnitude.
- in_op  input  1  0 = A-B, 1 = A+B.
- o_valid  output  1  result is valid.
- o_ready  input  1  downstream accepts the result.
- o_out  output  N  result, sign-magnitude.
- o_carry  output  1  magnitude overflow (carry out of the N-1 bit magnitude).
- o_zero  output  1  result magnitude is zero.

Behaviour:
- Reset (async, rst=1): both stage valid bits = 0, o_valid=0, o_out=0, o_carry=0, o_zero=0. Reset mid-operation discards all in-flight results; no result emerges after deassertion.
- Pipeline enable: en = o_ready | ~o_valid. in_ready = en, combinational from o_ready and the output valid register. When en=1, all stages shift; when en=0, all stages hold, including data.
- Transfer: input accepted when in_valid & in_ready; output consumed when o_valid & o_ready.
- Latency: 2 cycles, accept edge to o_valid. Throughput is 1 per cycle while o_ready=1. Bubbles propagate as valid=0.
- Stage 1 (registered on accept):
  - Store sA and magA.
  - Store the effective B sign: sB' = sB ^ ~in_op, so subtract flips B's sign.
  - Store eff_sub = sA ^ sB'.
  - Store a_ge_b = magA >= magB, plus magB.
- Stage 2 (registered):
  - eff_sub=0: {c, m} = magA + magB; sign = sA.
  - eff_sub=1 and a_ge_b: m = magA - magB; c = 0; sign = sA.
  - eff_sub=1 and not a_ge_b: m = magB - magA; c = 0; sign = sB'.
  - Overflow (c=1): SATURATE=0 keeps m wrapped; SATURATE=1 sets m to all-ones. o_carry = c in both modes.
  - Negative zero: if m == 0, the result sign is forced to 0 and o_zero=1. Inputs of -0 are treated as +0 by the same rule.
- Arithmetic width: the magnitude datapath is N bits (N-1 plus carry). Subtraction never borrows, because the larger magnitude is always the minuend.
- Stall with o_valid=1 and o_ready=0: o_out, o_carry and o_zero hold stable; in_ready=0. An input presented during the stall must be held by the source.
- Simultaneous consume and accept (o_ready=1, in_valid=1): both occur in the same cycle with no bubble.

Decomposition:
- Package sm_arith_pkg:
  - typedef enum logic {OP_SUB=0, OP_ADD=1} sm_op_e.
  - Functions sm_sign(x) and sm_mag(x), parametrised via N passed as argument width; these replace per-file macros.
  - Constant for the saturation magnitude pattern.
- Sub-module sm_mag_core: combinational N-1 bit magnitude add / ordered subtract with carry, instantiated in stage 2.

Test Plan (N=8):
- Subtract: in_a=0x05 (+5), in_b=0x03 (+3), op=0 -> after 2 cycles o_out=0x02, o_carry=0, o_zero=0.
- Sign flip and add mode: +3 - +5 (0x03, 0x05, op=0) -> o_out=0x82. Then -3 + +5 (0x83, 0x05, op=1) -> o_out=0x02.
- Overflow: +100 - (-100) (0x64, 0xE4, op=0) -> SATURATE=0 gives o_out=0x48, o_carry=1; SATURATE=1 gives o_out=0x7F, o_carry=1.
- Negative zero: -0 - +0 (0x80, 0x00, op=0) -> o_out=0x00, o_zero=1. Likewise +7 - +7 -> o_out=0x00, o_zero=1.
- Backpressure: stream 4 operand pairs with o_ready held low for 3 cycles mid-stream -> in_ready=0 during the stall, o_out stable, all 4 results in order with no loss or duplication.
- Reset mid-operation: assert rst one cycle after accepting a pair -> o_valid=0 immediately (async), no stale result appears after release, and the next accepted pair yields the correct result 2 cycles later.

Source files
------------

// File: rtl/sm_arith_pkg.sv
// Shared sign-magnitude helpers: op encoding, sign/magnitude field extraction and the
// saturation pattern. Helpers take the operand width as an argument so one copy serves any N.
package sm_arith_pkg;

   typedef enum logic {
      OP_SUB = 1'b0,
      OP_ADD = 1'b1
   } sm_op_e;

   localparam int unsigned SM_MAX_W = 64;

   // Slice [W-2:0] for a W-bit operand's clamped magnitude.
   localparam logic [SM_MAX_W-1:0] SM_SAT_MAG = '1;

   function automatic logic sm_sign(input logic [SM_MAX_W-1:0] x, input int unsigned n);
      return x[n-1];
   endfunction

   function automatic logic [SM_MAX_W-1:0] sm_mag(input logic [SM_MAX_W-1:0] x,
                                                  input int unsigned n);
      logic [SM_MAX_W-1:0] mask;
      mask = (SM_MAX_W'(1) << (n - 1)) - SM_MAX_W'(1);
      return x & mask;
   endfunction

endpackage

// File: rtl/sm_mag_core.sv
// Combinational magnitude unit: unsigned add with carry-out, or ordered subtract where the
// larger magnitude is always the minuend so no borrow can occur.
module sm_mag_core #(
   parameter int unsigned W = 7
) (
   input  logic [W-1:0] mag_a,
   input  logic [W-1:0] mag_b,
   input  logic         eff_sub,
   input  logic         a_ge_b,
   output logic [W-1:0] mag,
   output logic         carry
);

   logic [W:0] sum;

   always_comb begin
      sum   = {1'b0, mag_a} + {1'b0, mag_b};
      mag   = '0;
      carry = 1'b0;
      if (!eff_sub) begin
         {carry, mag} = sum;
      end else if (a_ge_b) begin
         mag = mag_a - mag_b;
      end else begin
         mag = mag_b - mag_a;
      end
   end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with valid/ready handshake,
// negative-zero normalisation and optional magnitude saturation.
module sm_addsub_pipe
   import sm_arith_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned SATURATE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic         in_op,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] o_out,
   output logic         o_carry,
   output logic         o_zero
);

   localparam int unsigned M = N - 1;

   logic         en;
   logic [M-1:0] in_mag_a;
   logic [M-1:0] in_mag_b;
   logic         in_sign_a;
   logic         in_sign_b_eff;

   logic         s1_valid_q;
   logic         s1_sign_a_q;
   logic         s1_sign_b_q;
   logic         s1_eff_sub_q;
   logic         s1_a_ge_b_q;
   logic [M-1:0] s1_mag_a_q;
   logic [M-1:0] s1_mag_b_q;

   logic [M-1:0] core_mag;
   logic         core_carry;
   logic [M-1:0] res_mag;
   logic         res_sign;
   logic         res_zero;

   // Whole pipeline advances together; the output register is the only backpressure point.
   assign en       = o_ready | ~o_valid;
   assign in_ready = en;

   assign in_mag_a  = M'(sm_mag(SM_MAX_W'(in_a), N));
   assign in_mag_b  = M'(sm_mag(SM_MAX_W'(in_b), N));
   assign in_sign_a = sm_sign(SM_MAX_W'(in_a), N);
   // Subtraction is addition of B with its sign flipped.
   assign in_sign_b_eff = sm_sign(SM_MAX_W'(in_b), N) ^ (sm_op_e'(in_op) != OP_ADD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_sign_a_q  <= 1'b0;
         s1_sign_b_q  <= 1'b0;
         s1_eff_sub_q <= 1'b0;
         s1_a_ge_b_q  <= 1'b0;
         s1_mag_a_q   <= '0;
         s1_mag_b_q   <= '0;
      end else if (en) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_a_q  <= in_sign_a;
            s1_sign_b_q  <= in_sign_b_eff;
            s1_eff_sub_q <= in_sign_a ^ in_sign_b_eff;
            s1_a_ge_b_q  <= (in_mag_a >= in_mag_b);
            s1_mag_a_q   <= in_mag_a;
            s1_mag_b_q   <= in_mag_b;
         end
      end
   end

   sm_mag_core #(
      .W (M)
   ) u_mag_core (
      .mag_a   (s1_mag_a_q),
      .mag_b   (s1_mag_b_q),
      .eff_sub (s1_eff_sub_q),
      .a_ge_b  (s1_a_ge_b_q),
      .mag     (core_mag),
      .carry   (core_carry)
   );

   always_comb begin
      res_mag = core_mag;
      if ((SATURATE != 0) && core_carry) begin
         res_mag = SM_SAT_MAG[M-1:0];
      end
      res_zero = (res_mag == '0);
      // A zero magnitude is always reported as +0, which also folds -0 inputs.
      if (res_zero) begin
         res_sign = 1'b0;
      end else if (s1_eff_sub_q && !s1_a_ge_b_q) begin
         res_sign = s1_sign_b_q;
      end else begin
         res_sign = s1_sign_a_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_out   <= '0;
         o_carry <= 1'b0;
         o_zero  <= 1'b0;
      end else if (en) begin
         o_valid <= s1_valid_q;
         if (s1_valid_q) begin
            o_out   <= {res_sign, res_mag};
            o_carry <= core_carry;
            o_zero  <= res_zero;
         end
      end
   end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Scoreboard bench for sm_addsub_pipe: wrapping and saturating instances share stimulus,
// expected results are queued on accept and checked by an independent output monitor.
module tb_sm_addsub_pipe;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
      logic [7:0] out_w;
      logic [7:0] out_s;
      logic       carry;
      logic       zero_w;
      logic       zero_s;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_op;
   logic       o_ready;

   logic       in_ready_w, o_valid_w, o_carry_w, o_zero_w;
   logic [7:0] o_out_w;
   logic       in_ready_s, o_valid_s, o_carry_s, o_zero_s;
   logic [7:0] o_out_s;

   int   n_cmp;
   int   n_bad;
   vec_t exp_q[$];
   vec_t vecs[10];
   vec_t e;
   logic stalled;
   logic [9:0] held;

   sm_addsub_pipe #(
      .N        (8),
      .SATURATE (0)
   ) dut_w (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_w),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_op    (in_op),
      .o_valid  (o_valid_w),
      .o_ready  (o_ready),
      .o_out    (o_out_w),
      .o_carry  (o_carry_w),
      .o_zero   (o_zero_w)
   );

   sm_addsub_pipe #(
      .N        (8),
      .SATURATE (1)
   ) dut_s (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_s),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_op    (in_op),
      .o_valid  (o_valid_s),
      .o_ready  (o_ready),
      .o_out    (o_out_s),
      .o_carry  (o_carry_s),
      .o_zero   (o_zero_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic send(input vec_t v);
      int k;
      in_a     = v.a;
      in_b     = v.b;
      in_op    = v.op;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready_w && k < 20) begin
         @(posedge clk);
         #2;
         k++;
      end
      if (!in_ready_w) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 20 cycles");
      end else begin
         exp_q.push_back(v);
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
         @(posedge clk);
      end
      #2;
      check("drain_pending", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else if (o_valid_w) begin
         if (!o_ready) begin
            check("stall_in_ready", {31'd0, in_ready_w}, 0);
            if (stalled) begin
               check("stall_hold", {22'd0, o_carry_w, o_zero_w, o_out_w}, {22'd0, held});
            end
            held    = {o_carry_w, o_zero_w, o_out_w};
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got o_out=0x%0h, expected no output", o_out_w);
            end else begin
               e = exp_q.pop_front();
               check("out_wrap", {24'd0, o_out_w}, {24'd0, e.out_w});
               check("carry_wrap", {31'd0, o_carry_w}, {31'd0, e.carry});
               check("zero_wrap", {31'd0, o_zero_w}, {31'd0, e.zero_w});
               check("valid_sat", {31'd0, o_valid_s}, 1);
               check("out_sat", {24'd0, o_out_s}, {24'd0, e.out_s});
               check("carry_sat", {31'd0, o_carry_s}, {31'd0, e.carry});
               check("zero_sat", {31'd0, o_zero_s}, {31'd0, e.zero_s});
            end
         end
      end else begin
         stalled = 1'b0;
      end
   end

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      stalled  = 1'b0;
      held     = '0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_op    = 1'b0;
      o_ready  = 1'b1;

      //            a      b      op    out_w  out_s  c     zw    zs
      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 1'b0, 8'h82, 8'h82, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'h83, 8'h05, 1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'h64, 8'hE4, 1'b0, 8'h48, 8'h7F, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{8'h07, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[6] = '{8'h0A, 8'h05, 1'b1, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{8'h85, 8'h02, 1'b1, 8'h83, 8'h83, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{8'h40, 8'h40, 1'b1, 8'h00, 8'h7F, 1'b1, 1'b1, 1'b0};
      vecs[9] = '{8'h81, 8'h81, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};

      repeat (2) @(posedge clk);
      #2;
      check("rst_valid_w", {31'd0, o_valid_w}, 0);
      check("rst_out_w", {24'd0, o_out_w}, 0);
      check("rst_carry_w", {31'd0, o_carry_w}, 0);
      check("rst_zero_w", {31'd0, o_zero_w}, 0);
      check("rst_valid_s", {31'd0, o_valid_s}, 0);
      check("rst_out_s", {24'd0, o_out_s}, 0);
      check("rst_in_ready", {31'd0, in_ready_w}, 1);
      rst = 1'b0;
      @(posedge clk);
      #2;

      for (int i = 0; i < 6; i++) begin
         send(vecs[i]);
      end
      in_valid = 1'b0;
      drain();

      // Stream four pairs while the sink stalls for three cycles.
      fork
         begin
            for (int i = 6; i < 10; i++) begin
               send(vecs[i]);
            end
            in_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1 o_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 o_ready = 1'b1;
         end
      join
      drain();

      // Flush two in-flight pairs with an asynchronous reset.
      send(vecs[0]);
      send(vecs[1]);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      exp_q.delete();
      #1;
      check("flush_valid_w", {31'd0, o_valid_w}, 0);
      check("flush_valid_s", {31'd0, o_valid_s}, 0);
      check("flush_out_w", {24'd0, o_out_w}, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #2;
         check("no_stale", {31'd0, o_valid_w}, 0);
      end
      send(vecs[2]);
      in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
